trig_handshake_gen: RTL

TRIG_HANDSHAKE_GEN -- requirements
Module: trig_handshake_gen

---
 rtl/trig_gen_pkg.sv | 23 ++
 rtl/trig_chan.sv | 142 ++++++++++++++
 rtl/trig_handshake_gen.sv | 64 ++++++
 3 files changed

// File: rtl/trig_gen_pkg.sv
// trig_gen_pkg
//   Shared definitions for the trigger handshake generator: the per-channel
//   FSM state encoding, the default register map / timeout constants and a
//   helper that maps a channel number onto its byte address.
//   No ports (package).
package trig_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_REL  = 2'd2
  } chan_state_e;

  localparam logic [10:0] DEF_BASE_ADDR   = 11'h008;
  localparam logic [10:0] DEF_LOST_ADDR   = 11'h00C;
  localparam int          DEF_TIMEOUT_CYC = 255;

  // Eight channels share one byte; channel chan lives in byte base + chan/8.
  function automatic logic [10:0] chan_byte_addr(input logic [10:0] base, input int chan);
    return base + 11'(chan / 8);
  endfunction

endpackage

// File: rtl/trig_chan.sv
// trig_chan
//   One four-phase trigger handshake channel: IDLE -> REQ (trig=1) until ack
//   is seen high -> REL (trig=0) until ack is seen low -> IDLE. Requests that
//   arrive while the handshake is in flight are dropped and flagged in a
//   sticky lost flag. Optional timeout (macro TRIG_HANDSHAKE_TIMEOUT_EN)
//   aborts a stuck handshake after TIMEOUT_CYC cycles and sets a sticky flag.
// Ports
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : request strobe for this channel (already address-decoded)
//   clr        : clear strobe for the sticky lost/timeout flags
//   ack        : acknowledge level from the destination
//   trig       : registered trigger request level
//   busy       : channel is not in IDLE
//   lost       : sticky, a request was dropped
//   timeout    : sticky, the handshake was aborted (0 without the macro)
module trig_chan
  import trig_gen_pkg::*;
#(
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic clr,
  input  logic ack,
  output logic trig,
  output logic busy,
  output logic lost,
  output logic timeout
);

  chan_state_e state_r;
  chan_state_e state_nx_s;
  logic        trig_r;
  logic        lost_r;
  logic        lost_set_s;
  logic        tmo_hit_s;
  logic        tmo_set_s;

`ifdef TRIG_HANDSHAKE_TIMEOUT_EN
  logic [15:0] cnt_r;
  logic [15:0] cnt_nx_s;
  logic        tmo_r;

  // Counter holds cycles already spent in the handshake, so the last
  // allowed cycle is TIMEOUT_CYC-1.
  assign tmo_hit_s = (cnt_r == 16'(TIMEOUT_CYC - 1));
`else
  logic tmo_unused_s;

  assign tmo_hit_s    = 1'b0;
  assign tmo_unused_s = tmo_set_s ^ (TIMEOUT_CYC == 0);
`endif

  // Next-state and flag-set decode for the handshake FSM.
  always_comb begin
    state_nx_s = state_r;
    lost_set_s = 1'b0;
    tmo_set_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // ack is deliberately ignored here
        if (req) begin
          state_nx_s = ST_REQ;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        lost_set_s = req;
        if (ack) begin
          state_nx_s = ST_REL;
        end else if (tmo_hit_s) begin
          state_nx_s = ST_IDLE;
          tmo_set_s  = 1'b1;
        end else begin
          state_nx_s = ST_REQ;
        end
      end
      ST_REL: begin
        lost_set_s = req;
        if (!ack) begin
          state_nx_s = ST_IDLE;
        end else if (tmo_hit_s) begin
          state_nx_s = ST_IDLE;
          tmo_set_s  = 1'b1;
        end else begin
          state_nx_s = ST_REL;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // State, registered trigger and sticky lost flag (set beats clear).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      trig_r  <= 1'b0;
      lost_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      trig_r  <= (state_nx_s == ST_REQ);
      lost_r  <= lost_set_s | (lost_r & ~clr);
    end
  end

`ifdef TRIG_HANDSHAKE_TIMEOUT_EN
  // Counter runs through REQ and REL and is zero whenever the channel is idle,
  // so it is already cleared in the first REQ cycle.
  always_comb begin
    cnt_nx_s = 16'd0;
    if ((state_r != ST_IDLE) && (state_nx_s != ST_IDLE)) begin
      cnt_nx_s = cnt_r + 16'd1;
    end else begin
      cnt_nx_s = 16'd0;
    end
  end

  // Timeout counter and sticky timeout flag (set beats clear).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= 16'd0;
      tmo_r <= 1'b0;
    end else begin
      cnt_r <= cnt_nx_s;
      tmo_r <= tmo_set_s | (tmo_r & ~clr);
    end
  end

  assign timeout = tmo_r;
`else
  assign timeout = 1'b0;
`endif

  assign trig = trig_r;
  assign busy = (state_r != ST_IDLE);
  assign lost = lost_r;

endmodule

// File: rtl/trig_handshake_gen.sv
// trig_handshake_gen
//   Register-mapped trigger generator. A write to BASE_ADDR + i/8 with bit
//   i%8 set starts a four-phase handshake on channel i; a write to
//   LOST_ADDR + i/8 clears its sticky lost/timeout flags. Optional
//   per-channel timeout is enabled with macro TRIG_HANDSHAKE_TIMEOUT_EN.
// Ports
//   clk, rst_n   : clock, asynchronous active-low reset
//   address      : 11-bit register address
//   wdata        : 8-bit write data
//   xfc          : write transfer complete strobe
//   trig_ack     : per-channel acknowledge level
//   trig         : per-channel trigger request level (registered)
//   trig_busy    : any channel not idle
//   trig_lost    : per-channel sticky dropped-request flag
//   trig_timeout : per-channel sticky timeout flag
module trig_handshake_gen
  import trig_gen_pkg::*;
#(
  parameter int          NUM_TRIG    = 8,
  parameter logic [10:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter logic [10:0] LOST_ADDR   = DEF_LOST_ADDR,
  parameter int          TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [10:0]         address,
  input  logic [7:0]          wdata,
  input  logic                xfc,
  input  logic [NUM_TRIG-1:0] trig_ack,
  output logic [NUM_TRIG-1:0] trig,
  output logic                trig_busy,
  output logic [NUM_TRIG-1:0] trig_lost,
  output logic [NUM_TRIG-1:0] trig_timeout
);

  logic [NUM_TRIG-1:0] busy_s;

  // Only populated bytes/bits are decoded, so writes beyond the last
  // channel fall through with no effect.
  for (genvar i = 0; i < NUM_TRIG; i++) begin : g_chan
    logic req_s;
    logic clr_s;

    assign req_s = xfc & (address == chan_byte_addr(BASE_ADDR, i)) & wdata[i % 8];
    assign clr_s = xfc & (address == chan_byte_addr(LOST_ADDR, i)) & wdata[i % 8];

    trig_chan #(
      .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (req_s),
      .clr    (clr_s),
      .ack    (trig_ack[i]),
      .trig   (trig[i]),
      .busy   (busy_s[i]),
      .lost   (trig_lost[i]),
      .timeout(trig_timeout[i])
    );
  end

  assign trig_busy = |busy_s;

endmodule
